// File: rtl/line_buf_sched_if.sv
// Pulse/status bundle between the CSI decoder + interpolator side (master)
// and the line-buffer slot scheduler (slave).
interface line_buf_sched_if #(
  parameter int NUM_SLOTS = 4,
  parameter int MAX_ROWS  = 1080
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = $clog2(NUM_SLOTS + 1);
  localparam int ROW_W  = $clog2(MAX_ROWS + 1);

  logic              frame_start;
  logic              frame_end;
  logic              line_start;
  logic              line_end;
  logic              rd_done;
  logic              wr_active;
  logic [SLOT_W-1:0] wr_sel;
  logic              rd_start;
  logic              rd_busy;
  logic [SLOT_W-1:0] rd_base;
  logic [CNT_W-1:0]  fill_cnt;
  logic [ROW_W-1:0]  row_cnt;
  logic              overflow;
  logic              proto_err;

  modport master (
    output frame_start, frame_end, line_start, line_end, rd_done,
    input  wr_active, wr_sel, rd_start, rd_busy, rd_base, fill_cnt, row_cnt,
           overflow, proto_err
  );

  modport slave (
    input  frame_start, frame_end, line_start, line_end, rd_done,
    output wr_active, wr_sel, rd_start, rd_busy, rd_base, fill_cnt, row_cnt,
           overflow, proto_err
  );
endinterface

// File: rtl/line_buf_sched.sv
// Slot scheduler for the de-Bayer line buffer: assigns sensor lines to slots
// and launches one window read per output row once WIN_LINES lines are held.
module line_buf_sched #(
  parameter int NUM_SLOTS = 4,
  parameter int WIN_LINES = 3,
  parameter int MAX_ROWS  = 1080
) (
  input logic             clk,
  input logic             rst,
  line_buf_sched_if.slave bus
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = $clog2(NUM_SLOTS + 1);
  localparam int ROW_W  = $clog2(MAX_ROWS + 1);

  localparam logic [CNT_W-1:0] FULL    = CNT_W'(NUM_SLOTS);
  localparam logic [CNT_W-1:0] WIN     = CNT_W'(WIN_LINES);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(MAX_ROWS);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t            state;
  logic              wr_active;
  logic              rd_start;
  logic              rd_busy;
  logic              overflow;
  logic              proto_err;
  logic [SLOT_W-1:0] wr_sel;
  logic [SLOT_W-1:0] rd_base;
  logic [CNT_W-1:0]  fill_cnt;
  logic [CNT_W-1:0]  fill_next;
  logic [ROW_W-1:0]  row_cnt;

  logic line_ok, read_state, rd_fire, wr_open, wr_drop, wr_commit;
  logic rd_retire, seq_err, drain_done;

  // Lines are only written in FILL/RUN; IDLE ignores them, DRAIN flags them.
  assign line_ok    = (state == FILL) || (state == RUN);
  assign read_state = (state == RUN) || (state == DRAIN);

  assign rd_fire    = read_state && (fill_cnt >= WIN) && !rd_busy && (row_cnt < ROW_MAX);
  assign wr_open    = line_ok && bus.line_start && !wr_active && (fill_cnt != FULL);
  assign wr_drop    = line_ok && bus.line_start && !wr_active && (fill_cnt == FULL);
  assign wr_commit  = line_ok && bus.line_end && wr_active;
  assign rd_retire  = (state != IDLE) && bus.rd_done && rd_busy;
  assign drain_done = (state == DRAIN) && !rd_busy && !rd_fire;

  assign seq_err = (line_ok && ((bus.line_end && !wr_active) || (bus.line_start && wr_active)))
                || ((state == DRAIN) && (bus.line_start || bus.line_end))
                || ((state != IDLE) && bus.rd_done && !rd_busy);

  // A coincident commit and retire leave the occupancy unchanged.
  always_comb begin
    // NOTE: default assignment first so every path drives fill_next and no latch is inferred.
    fill_next = fill_cnt;
    if (wr_commit && !rd_retire)      fill_next = fill_cnt + CNT_W'(1);
    else if (rd_retire && !wr_commit) fill_next = fill_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      state     <= IDLE;
      wr_active <= 1'b0;
      wr_sel    <= '0;
      rd_start  <= 1'b0;
      rd_busy   <= 1'b0;
      rd_base   <= '0;
      fill_cnt  <= '0;
      row_cnt   <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else if (bus.frame_start) begin
      state     <= FILL;
      wr_active <= 1'b0;
      wr_sel    <= '0;
      rd_start  <= 1'b0;
      rd_busy   <= 1'b0;
      rd_base   <= '0;
      fill_cnt  <= '0;
      row_cnt   <= '0;
      if (state == IDLE) begin
        overflow  <= 1'b0;
        proto_err <= 1'b0;
      end else begin
        proto_err <= 1'b1;
      end
    end else begin
      rd_start <= rd_fire;
      fill_cnt <= fill_next;

      if (rd_fire)        rd_busy <= 1'b1;
      else if (rd_retire) rd_busy <= 1'b0;

      if (wr_commit) begin
        wr_active <= 1'b0;
        wr_sel    <= wr_sel + SLOT_W'(1);
      end else if (wr_open) begin
        wr_active <= 1'b1;
      end

      if (rd_retire) begin
        rd_base <= rd_base + SLOT_W'(1);
        if (row_cnt != ROW_MAX) row_cnt <= row_cnt + ROW_W'(1);
      end

      if (wr_drop) overflow  <= 1'b1;
      if (seq_err) proto_err <= 1'b1;

      case (state)
        FILL: begin
          if (bus.frame_end)       state <= DRAIN;
          else if (fill_next >= WIN) state <= RUN;
        end
        RUN: begin
          if (bus.frame_end) state <= DRAIN;
        end
        DRAIN: begin
          // Leftover partial window is discarded; the write pointer rejoins
          // the read pointer so the slot ring stays consistent.
          if (drain_done) begin
            wr_active <= 1'b0;
            if (fill_cnt == '0) begin
              state <= IDLE;
            end else begin
              fill_cnt <= '0;
              wr_sel   <= rd_base;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_active = wr_active;
  assign bus.wr_sel    = wr_sel;
  assign bus.rd_start  = rd_start;
  assign bus.rd_busy   = rd_busy;
  assign bus.rd_base   = rd_base;
  assign bus.fill_cnt  = fill_cnt;
  assign bus.row_cnt   = row_cnt;
  assign bus.overflow  = overflow;
  assign bus.proto_err = proto_err;

  a_fill_bound: assert property (@(posedge clk) disable iff (rst) fill_cnt <= FULL);
  a_ptr_gap:    assert property (@(posedge clk) disable iff (rst)
                  wr_sel == rd_base + fill_cnt[SLOT_W-1:0]);
  a_busy_win:   assert property (@(posedge clk) disable iff (rst) rd_busy |-> fill_cnt >= WIN);
endmodule

// File: tb/tb_line_buf_sched.sv
// Self-checking bench for line_buf_sched: directed scenarios plus random
// pulses, every cycle compared against a count-based reference model.
module tb_line_buf_sched;
  localparam int MAXR    = 1080;
  localparam int S_IDLE  = 0;
  localparam int S_FILL  = 1;
  localparam int S_RUN   = 2;
  localparam int S_DRAIN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_buf_sched_if lb ();
  line_buf_sched dut (.clk(clk), .rst(rst), .bus(lb));

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy is lines written minus lines retired, and the
  // slot pointers are those totals modulo the ring size.
  int m_state   = S_IDLE;
  int m_written = 0;
  int m_retired = 0;
  int m_rows    = 0;
  bit m_wr_active, m_busy, m_rd_start, m_ovf, m_perr;

  // Interpolator responder: rd_done rd_lat cycles after each rd_start.
  bit auto_rd  = 1'b0;
  int rd_lat   = 1;
  int rd_timer = -1;
  int rd_fired = 0;

  task automatic model_edge(input bit r, input bit fs, input bit fe,
                            input bit ls, input bit le, input bit rd);
    int  fill;
    bit  start_now, busy_n, wa_n;
    fill = m_written - m_retired;
    if (r) begin
      m_state = S_IDLE; m_written = 0; m_retired = 0; m_rows = 0;
      m_wr_active = 0; m_busy = 0; m_rd_start = 0; m_ovf = 0; m_perr = 0;
      return;
    end
    if (fs) begin
      if (m_state != S_IDLE) m_perr = 1;
      else begin m_ovf = 0; m_perr = 0; end
      m_state = S_FILL; m_written = 0; m_retired = 0; m_rows = 0;
      m_wr_active = 0; m_busy = 0; m_rd_start = 0;
      return;
    end
    if (m_state == S_IDLE) begin
      m_rd_start = 0;
      return;
    end
    start_now = (m_state == S_RUN || m_state == S_DRAIN) && fill >= 3 && !m_busy && m_rows < MAXR;
    busy_n = m_busy;
    wa_n   = m_wr_active;
    if (m_state == S_DRAIN) begin
      if (ls || le) m_perr = 1;
    end else begin
      if (le) begin
        if (m_wr_active) begin wa_n = 0; m_written++; end
        else m_perr = 1;
      end
      if (ls) begin
        if (m_wr_active) m_perr = 1;
        else if (fill == 4) m_ovf = 1;
        else wa_n = 1;
      end
    end
    if (rd) begin
      if (m_busy) begin
        busy_n = 0; m_retired++;
        if (m_rows < MAXR) m_rows++;
      end else m_perr = 1;
    end
    if (start_now) busy_n = 1;
    if (m_state == S_DRAIN && !start_now && !m_busy) begin
      wa_n = 0;
      if (fill == 0) m_state = S_IDLE;
      else m_written = m_retired;
    end else if (fe && m_state != S_DRAIN) begin
      m_state = S_DRAIN;
    end else if (m_state == S_FILL && (m_written - m_retired) >= 3) begin
      m_state = S_RUN;
    end
    m_rd_start  = start_now;
    m_busy      = busy_n;
    m_wr_active = wa_n;
  endtask

  // One clock: drive pulses, advance DUT and model, compare all outputs.
  task automatic step(input bit fs, input bit fe, input bit ls, input bit le, input bit rd);
    bit rd_in;
    logic [22:0] got, exp;
    rd_in = rd;
    if (auto_rd && rd_timer == 0) begin
      rd_in = 1'b1; rd_timer = -1; rd_fired++;
    end
    lb.frame_start = fs; lb.frame_end = fe; lb.line_start = ls;
    lb.line_end = le; lb.rd_done = rd_in;
    @(posedge clk);
    model_edge(rst, fs, fe, ls, le, rd_in);
    if (m_rd_start && auto_rd) rd_timer = rd_lat - 1;
    else if (rd_timer > 0) rd_timer--;
    #1;
    lb.frame_start = 0; lb.frame_end = 0; lb.line_start = 0; lb.line_end = 0; lb.rd_done = 0;
    got = {lb.wr_active, lb.wr_sel, lb.rd_start, lb.rd_busy, lb.rd_base,
           lb.fill_cnt, lb.row_cnt, lb.overflow, lb.proto_err};
    exp = {m_wr_active, 2'(m_written % 4), m_rd_start, m_busy, 2'(m_retired % 4),
           3'(m_written - m_retired), 11'(m_rows), m_ovf, m_perr};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got wa=%b ws=%0d rs=%b rb=%b base=%0d fill=%0d rows=%0d ovf=%b perr=%b expected wa=%b ws=%0d rs=%b rb=%b base=%0d fill=%0d rows=%0d ovf=%b perr=%b",
               $time, got[22], got[21:20], got[19], got[18], got[17:16], got[15:13], got[12:2], got[1], got[0],
               exp[22], exp[21:20], exp[19], exp[18], exp[17:16], exp[15:13], exp[12:2], exp[1], exp[0]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic write_line(input int gap);
    step(0, 0, 1, 0, 0);
    idle(gap);
    step(0, 0, 0, 1, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    checks++;
    if ({lb.wr_active, lb.wr_sel, lb.rd_start, lb.rd_busy, lb.rd_base, lb.fill_cnt,
         lb.row_cnt, lb.overflow, lb.proto_err} !== 23'd0) begin
      errors++;
      $display("FAIL reset_values got wa=%b ws=%0d rs=%b rb=%b base=%0d fill=%0d rows=%0d ovf=%b perr=%b expected all zero",
               lb.wr_active, lb.wr_sel, lb.rd_start, lb.rd_busy, lb.rd_base, lb.fill_cnt,
               lb.row_cnt, lb.overflow, lb.proto_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_window();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      write_line(639);
      checks++;
      if (lb.fill_cnt !== 3'(i + 1)) begin
        errors++;
        $display("FAIL first_fill got %0d expected %0d", lb.fill_cnt, i + 1);
      end
    end
    checks++;
    if (lb.rd_start !== 1'b0) begin
      errors++; $display("FAIL rd_start_early got %b expected 0", lb.rd_start);
    end
    idle(1);
    checks++;
    if ({lb.rd_start, lb.rd_busy, lb.rd_base, lb.wr_sel} !== {1'b1, 1'b1, 2'd0, 2'd3}) begin
      errors++;
      $display("FAIL first_read got rs=%b rb=%b base=%0d ws=%0d expected rs=1 rb=1 base=0 ws=3",
               lb.rd_start, lb.rd_busy, lb.rd_base, lb.wr_sel);
    end
  endtask

  task automatic t2_step(input bit ls, input bit le);
    step(0, 0, ls, le, 0);
    checks++;
    if (lb.row_cnt !== 11'(rd_fired) || lb.overflow !== 1'b0) begin
      errors++;
      $display("FAIL steady_rows got rows=%0d ovf=%b expected rows=%0d ovf=0",
               lb.row_cnt, lb.overflow, rd_fired);
    end
  endtask

  task automatic test_steady_state();
    int guard;
    auto_rd = 1'b1; rd_lat = 700; rd_timer = 699; rd_fired = 0;
    for (int n = 0; n < 10; n++) begin
      guard = 0;
      while ((m_written - m_retired) >= 4 && guard < 2000) begin
        t2_step(0, 0); guard++;
      end
      checks++;
      if (guard >= 2000) begin errors++; $display("FAIL steady_space_wait got timeout expected free slot"); end
      t2_step(1, 0);
      repeat (639) t2_step(0, 0);
      t2_step(0, 1);
    end
    guard = 0;
    while (rd_fired < 8 && guard < 3000) begin t2_step(0, 0); guard++; end
    checks++;
    if (guard >= 3000) begin errors++; $display("FAIL steady_reads got %0d reads expected 8", rd_fired); end
    checks++;
    if (lb.wr_sel !== 2'd1 || lb.rd_base !== 2'(rd_fired % 4)) begin
      errors++;
      $display("FAIL steady_ptrs got ws=%0d base=%0d expected ws=1 base=%0d",
               lb.wr_sel, lb.rd_base, rd_fired % 4);
    end
  endtask

  task automatic test_overflow();
    int  n;
    logic [1:0] ws_before;
    auto_rd = 1'b0; rd_timer = -1;
    n = 0;
    while ((m_written - m_retired) < 4 && n < 8) begin write_line(20); n++; end
    idle(2);
    checks++;
    if (lb.fill_cnt !== 3'd4 || lb.rd_busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_full got fill=%0d rb=%b expected fill=4 rb=1", lb.fill_cnt, lb.rd_busy);
    end
    ws_before = 2'(m_written % 4);
    step(0, 0, 1, 0, 0);
    checks++;
    if (lb.wr_active !== 1'b0 || lb.overflow !== 1'b1 || lb.wr_sel !== ws_before) begin
      errors++;
      $display("FAIL overflow_drop got wa=%b ovf=%b ws=%0d expected wa=0 ovf=1 ws=%0d",
               lb.wr_active, lb.overflow, lb.wr_sel, ws_before);
    end
    idle(3);
  endtask

  task automatic test_coincident();
    logic [1:0] exp_ws, exp_base;
    step(0, 0, 0, 0, 1);
    idle(1);
    step(0, 0, 1, 0, 0);
    idle(10);
    exp_ws   = 2'((m_written + 1) % 4);
    exp_base = 2'((m_retired + 1) % 4);
    step(0, 0, 0, 1, 1);
    checks++;
    if (lb.fill_cnt !== 3'd3 || lb.wr_sel !== exp_ws || lb.rd_base !== exp_base || lb.rd_busy !== 1'b0) begin
      errors++;
      $display("FAIL coincident got fill=%0d ws=%0d base=%0d rb=%b expected fill=3 ws=%0d base=%0d rb=0",
               lb.fill_cnt, lb.wr_sel, lb.rd_base, lb.rd_busy, exp_ws, exp_base);
    end
  endtask

  task automatic test_drain();
    int rows0;
    idle(1);
    write_line(3);
    checks++;
    if (lb.fill_cnt !== 3'd4 || lb.rd_busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_entry got fill=%0d rb=%b expected fill=4 rb=1", lb.fill_cnt, lb.rd_busy);
    end
    rows0 = m_rows;
    step(0, 1, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 1);
    idle(1);
    checks++;
    if (lb.rd_start !== 1'b1) begin errors++; $display("FAIL drain_second_read got rs=%b expected 1", lb.rd_start); end
    idle(3);
    step(0, 0, 0, 0, 1);
    idle(1);
    checks++;
    if (lb.fill_cnt !== 3'd0) begin errors++; $display("FAIL drain_flush got fill=%0d expected 0", lb.fill_cnt); end
    idle(1);
    checks++;
    if (lb.row_cnt !== 11'(rows0 + 2)) begin
      errors++; $display("FAIL drain_rows got %0d expected %0d", lb.row_cnt, rows0 + 2);
    end
    step(0, 0, 1, 0, 0);
    checks++;
    if (lb.wr_active !== 1'b0 || lb.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore got wa=%b perr=%b expected wa=0 perr=0", lb.wr_active, lb.proto_err);
    end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_resync_and_reset();
    step(1, 0, 0, 0, 0);
    checks++;
    if (lb.overflow !== 1'b0) begin errors++; $display("FAIL frame_clear got ovf=%b expected 0", lb.overflow); end
    repeat (3) write_line(4);
    idle(3);
    step(1, 0, 0, 0, 0);
    checks++;
    if ({lb.proto_err, lb.rd_busy, lb.fill_cnt, lb.wr_sel, lb.rd_base, lb.row_cnt} !== {1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 11'd0}) begin
      errors++;
      $display("FAIL resync got perr=%b rb=%b fill=%0d ws=%0d base=%0d rows=%0d expected perr=1 rb=0 fill=0 ws=0 base=0 rows=0",
               lb.proto_err, lb.rd_busy, lb.fill_cnt, lb.wr_sel, lb.rd_base, lb.row_cnt);
    end
    repeat (3) write_line(4);
    idle(2);
    checks++;
    if (lb.rd_busy !== 1'b1) begin errors++; $display("FAIL resync_refill got rb=%b expected 1", lb.rd_busy); end
    pulse_reset();
    checks++;
    if ({lb.wr_active, lb.wr_sel, lb.rd_start, lb.rd_busy, lb.rd_base, lb.fill_cnt,
         lb.row_cnt, lb.overflow, lb.proto_err} !== 23'd0) begin
      errors++; $display("FAIL reset_mid_read got nonzero outputs expected all zero");
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (lb.proto_err !== 1'b0 || lb.rd_busy !== 1'b0) begin
      errors++;
      $display("FAIL stale_rd_done got perr=%b rb=%b expected perr=0 rb=0", lb.proto_err, lb.rd_busy);
    end
  endtask

  task automatic test_row_saturate();
    int guard;
    pulse_reset();
    step(1, 0, 0, 0, 0);
    auto_rd = 1'b1; rd_lat = 1; rd_timer = -1;
    guard = 0;
    while (m_rows < MAXR && guard < 12000) begin
      if (m_wr_active) step(0, 0, 0, 1, 0);
      else if ((m_written - m_retired) < 4) step(0, 0, 1, 0, 0);
      else step(0, 0, 0, 0, 0);
      guard++;
    end
    checks++;
    if (guard >= 12000) begin errors++; $display("FAIL saturate_wait got timeout expected %0d rows", MAXR); end
    idle(12);
    checks++;
    if (lb.row_cnt !== 11'(MAXR) || lb.rd_busy !== 1'b0 || lb.rd_start !== 1'b0) begin
      errors++;
      $display("FAIL row_saturate got rows=%0d rb=%b rs=%b expected rows=%0d rb=0 rs=0",
               lb.row_cnt, lb.rd_busy, lb.rd_start, MAXR);
    end
    auto_rd = 1'b0; rd_timer = -1;
  endtask

  task automatic test_random();
    bit fs, fe, ls, le, rd;
    int r;
    pulse_reset();
    step(1, 0, 0, 0, 0);
    auto_rd = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rd_lat = $urandom_range(1, 12);
      r  = $urandom_range(0, 999);
      fs = (r < 3);
      fe = (r >= 3 && r < 8);
      ls = m_wr_active ? ($urandom_range(0, 99) < 2)  : ($urandom_range(0, 99) < 30);
      le = m_wr_active ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 2);
      rd = ($urandom_range(0, 199) == 0);
      if (m_state == S_IDLE && $urandom_range(0, 19) == 0) fs = 1'b1;
      step(fs, fe, ls, le, rd);
    end
    auto_rd = 1'b0; rd_timer = -1;
  endtask

  initial begin
    lb.frame_start = 0; lb.frame_end = 0; lb.line_start = 0; lb.line_end = 0; lb.rd_done = 0;
    test_reset();
    test_first_window();
    test_steady_state();
    test_overflow();
    test_coincident();
    test_drain();
    test_resync_and_reset();
    test_row_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
